// File: rtl/main_memory_pkg.sv
// Shared types and default geometry for the MainBus memory responder.
package main_memory_pkg;

  localparam int DATABUSWIDTH_DEF = 64;
  localparam int MEM_LINES_DEF    = 1024;
  localparam int LATENCY_DEF      = 4;
  localparam int LINE_IDX_W       = $clog2(MEM_LINES_DEF);

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} mem_state_e;
  typedef enum logic {RD, WR} mem_op_e;

  function automatic int line_idx_width(input int lines);
    return (lines > 1) ? $clog2(lines) : 1;
  endfunction

endpackage

// File: rtl/main_memory_mem_array.sv
// Single-port synchronous line RAM: write-enable, registered read, no reset.
module mem_array #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 64,
  parameter int AW    = 10
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/main_memory.sv
// Fixed-latency line-granular memory responder with saturating Dragon snoop counters.
module main_memory
  import main_memory_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATABUSWIDTH = DATABUSWIDTH_DEF,
  parameter int MEM_LINES    = MEM_LINES_DEF,
  parameter int LATENCY      = LATENCY_DEF,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic                    READ,
  input  logic                    WRITE,
  input  logic [DATABUSWIDTH-1:0] DataOut,
  input  logic                    BusRd,
  input  logic                    BusUpd,
  output logic [DATABUSWIDTH-1:0] DataIn,
  output logic                    MemReady,
  output logic                    Busy,
  output logic [CNT_WIDTH-1:0]    bus_rd_count,
  output logic [CNT_WIDTH-1:0]    bus_upd_count
);

  localparam int OFF   = $clog2(DATABUSWIDTH / 8);
  localparam int IDX_W = line_idx_width(MEM_LINES);
  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(LATENCY - 1);

  mem_state_e              state_q, state_d;
  mem_op_e                 op_q, op_d;
  logic [IDX_W-1:0]        addr_q, addr_d;
  logic [DATABUSWIDTH-1:0] wdata_q, wdata_d;
  logic [LAT_W-1:0]        lat_q, lat_d;
  logic [DATABUSWIDTH-1:0] data_in_q, data_in_d;
  logic                    mem_ready_q, mem_ready_d;
  logic [CNT_WIDTH-1:0]    rd_cnt_q, rd_cnt_d;
  logic [CNT_WIDTH-1:0]    upd_cnt_q, upd_cnt_d;

  logic [IDX_W-1:0]        req_idx;
  logic [IDX_W-1:0]        ram_addr;
  logic [DATABUSWIDTH-1:0] ram_rdata;
  logic                    last_access;
  logic                    ram_we;
  logic                    unused_addr;

  assign req_idx     = address[OFF +: IDX_W];
  assign unused_addr = ^address;
  // RAM reads continuously; in IDLE it is pointed at the incoming line so LATENCY=1 still works.
  assign ram_addr    = (state_q == IDLE) ? req_idx : addr_q;
  assign last_access = (state_q == ACCESS) && (lat_q == '0);
  assign ram_we      = last_access && (op_q == WR) && !reset;

  mem_array #(
    .DEPTH (MEM_LINES),
    .WIDTH (DATABUSWIDTH),
    .AW    (IDX_W)
  ) u_mem_array (
    .clock (clock),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    lat_d       = lat_q;
    data_in_d   = data_in_q;
    mem_ready_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (WRITE) begin
          op_d    = WR;
          addr_d  = req_idx;
          wdata_d = DataOut;
          lat_d   = LAT_INIT;
          state_d = ACCESS;
        end else if (READ) begin
          op_d    = RD;
          addr_d  = req_idx;
          lat_d   = LAT_INIT;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (lat_q == '0) begin
          state_d     = RESPOND;
          mem_ready_d = 1'b1;
          if (op_q == RD) data_in_d = ram_rdata;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    rd_cnt_d  = (BusRd && (rd_cnt_q != '1)) ? rd_cnt_q + CNT_WIDTH'(1) : rd_cnt_q;
    upd_cnt_d = (BusUpd && (upd_cnt_q != '1)) ? upd_cnt_q + CNT_WIDTH'(1) : upd_cnt_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      data_in_q   <= '0;
      mem_ready_q <= 1'b0;
      rd_cnt_q    <= '0;
      upd_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      data_in_q   <= data_in_d;
      mem_ready_q <= mem_ready_d;
      rd_cnt_q    <= rd_cnt_d;
      upd_cnt_q   <= upd_cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    op_q    <= op_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign DataIn        = data_in_q;
  assign MemReady      = mem_ready_q;
  assign Busy          = (state_q != IDLE);
  assign bus_rd_count  = rd_cnt_q;
  assign bus_upd_count = upd_cnt_q;

endmodule

// File: tb/tb_main_memory.sv
// Directed plus randomized checks of main_memory against a line-array reference model.
module tb_main_memory;

  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int ML  = 1024;
  localparam int LAT = 4;
  localparam int CW  = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] address;
  logic          READ, WRITE, BusRd, BusUpd;
  logic [DW-1:0] DataOut;
  logic [DW-1:0] DataIn;
  logic          MemReady, Busy;
  logic [CW-1:0] bus_rd_count, bus_upd_count;

  main_memory #(
    .ADDR_WIDTH(AW), .DATABUSWIDTH(DW), .MEM_LINES(ML), .LATENCY(LAT), .CNT_WIDTH(CW)
  ) dut (
    .clock(clock), .reset(reset), .address(address), .READ(READ), .WRITE(WRITE),
    .DataOut(DataOut), .BusRd(BusRd), .BusUpd(BusUpd), .DataIn(DataIn),
    .MemReady(MemReady), .Busy(Busy), .bus_rd_count(bus_rd_count),
    .bus_upd_count(bus_upd_count)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  logic [DW-1:0] model_mem [int];
  logic [DW-1:0] exp_datain = '0;
  int            exp_rd  = 0;
  int            exp_upd = 0;
  bit            rand_strobes = 1'b0;
  int            wlines[$];

  function automatic int line_of(input logic [AW-1:0] a);
    return int'((a / 8) % ML);
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply the model for the cycle just finished, then move to the next cycle.
  task automatic end_cycle();
    if (reset) begin
      exp_rd = 0; exp_upd = 0; exp_datain = '0;
    end else begin
      if (BusRd)  exp_rd  = (exp_rd  < CNT_MAX) ? exp_rd + 1  : CNT_MAX;
      if (BusUpd) exp_upd = (exp_upd < CNT_MAX) ? exp_upd + 1 : CNT_MAX;
    end
    @(posedge clock);
    #1;
    if (rand_strobes) begin
      BusRd  = ($urandom_range(0, 7) == 0);
      BusUpd = ($urandom_range(0, 7) == 0);
    end
  endtask

  task automatic idle_check(input string tag);
    @(negedge clock);
    chk({tag, "/busy"}, Busy, '0);
    chk({tag, "/rdy"}, MemReady, '0);
    chk({tag, "/datain"}, DataIn, exp_datain);
    chk({tag, "/rdcnt"}, bus_rd_count, exp_rd);
    chk({tag, "/updcnt"}, bus_upd_count, exp_upd);
    end_cycle();
  endtask

  task automatic txn(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input bit drop_rd, input bit drop_wr, input bit chg, input string tag);
    int ln;
    ln = line_of(a);
    READ = rd; WRITE = wr; address = a; DataOut = d;
    for (int c = 0; c <= LAT + 1; c++) begin
      if (chg && c == 2) begin
        address = a ^ 32'h400;
        DataOut = ~d;
      end
      @(negedge clock);
      chk({tag, "/busy"}, Busy, (c >= 1) ? 64'd1 : 64'd0);
      chk({tag, "/rdy"}, MemReady, (c == LAT + 1) ? 64'd1 : 64'd0);
      if (c == LAT + 1) begin
        if (wr) model_mem[ln] = d;
        else    exp_datain = model_mem[ln];
        chk({tag, "/datain"}, DataIn, exp_datain);
      end
      end_cycle();
    end
    if (drop_rd) READ = 1'b0;
    if (drop_wr) WRITE = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic [DW-1:0] rd_data;
    int            ln;

    reset = 1'b1; READ = 0; WRITE = 0; BusRd = 0; BusUpd = 0; address = '0; DataOut = '0;
    #1;
    end_cycle();
    end_cycle();
    reset = 1'b0;
    idle_check("reset");

    txn(0, 1, 32'h40, 64'hDEADBEEF_CAFEF00D, 0, 1, 0, "wr40");
    txn(1, 0, 32'h40, '0, 1, 0, 0, "rd40");
    chk("rd40/value", DataIn, 64'hDEADBEEF_CAFEF00D);
    txn(1, 0, 32'h2040, '0, 1, 0, 0, "rd_alias");
    chk("rd_alias/value", DataIn, 64'hDEADBEEF_CAFEF00D);
    txn(0, 1, 32'h48, 64'h1234, 0, 1, 0, "wr_line9");
    chk("wr_line9/datain_kept", DataIn, 64'hDEADBEEF_CAFEF00D);
    idle_check("gap1");

    txn(1, 1, 32'h80, 64'h1, 0, 1, 0, "both_wr");
    txn(1, 0, 32'h80, '0, 1, 0, 0, "both_rd");
    chk("both_rd/value", DataIn, 64'h1);

    txn(0, 1, 32'h700, 64'h5555, 0, 1, 0, "pre700");
    txn(0, 1, 32'h300, 64'h3333_0000_CCCC, 0, 1, 1, "chg300");
    txn(1, 0, 32'h300, '0, 1, 0, 0, "rd300");
    txn(1, 0, 32'h700, '0, 1, 0, 0, "rd700");
    chk("rd700/value", DataIn, 64'h5555);

    txn(0, 1, 32'h100, 64'hAA, 0, 1, 0, "wrAA");
    READ = 0; WRITE = 1; address = 32'h100; DataOut = 64'hBB;
    for (int c = 0; c <= 2; c++) begin
      if (c == 2) begin
        reset = 1'b1;
        WRITE = 1'b0;
      end
      @(negedge clock);
      chk("rstmid/busy", Busy, (c >= 1) ? 64'd1 : 64'd0);
      chk("rstmid/rdy", MemReady, '0);
      end_cycle();
    end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) idle_check("rstmid/idle");
    txn(1, 0, 32'h100, '0, 1, 0, 0, "rd100");
    chk("rd100/value", DataIn, 64'hAA);

    for (int i = 0; i < 23; i++) begin
      BusUpd = (i < 20);
      BusRd  = (i == 18 || i == 19 || i == 22);
      end_cycle();
    end
    BusRd = 0; BusUpd = 0;
    idle_check("cnt");
    chk("cnt/rd3", bus_rd_count, 64'd3);
    chk("cnt/upd_sat", bus_upd_count, 64'd15);
    reset = 1'b1;
    end_cycle();
    reset = 1'b0;
    idle_check("cnt_reset");
    chk("cnt_reset/rd0", bus_rd_count, '0);

    rand_strobes = 1'b1;
    foreach (model_mem[k]) wlines.push_back(k);
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        ln = $urandom_range(0, ML - 1);
        ra = ($urandom() & ~32'h1FF8) | (ln << 3);
        rd_data = {$urandom(), $urandom()};
        txn(0, 1, ra, rd_data, 0, 1, 0, "rnd_wr");
        wlines.push_back(ln);
      end else begin
        ln = wlines[$urandom_range(0, wlines.size() - 1)];
        ra = ($urandom() & ~32'h1FF8) | (ln << 3);
        txn(1, 0, ra, '0, 1, 0, 0, "rnd_rd");
      end
      if ($urandom_range(0, 2) == 0) idle_check("rnd_gap");
    end
    rand_strobes = 1'b0;
    BusRd = 0; BusUpd = 0;
    end_cycle();
    idle_check("rnd_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
